// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc_plus4} pairs. Flush clears all
// entries and wins over push/pop in the same cycle. popData reads zero when
// empty so downstream sees clean outputs.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2 * INSTR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         popData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int             PW   = $clog2(DEPTH);
    localparam logic [PW:0]    FULL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign doPush  = push && (count != FULL) && !flush;
    assign doPop   = pop && !empty && !flush;
    assign popData = empty ? '0 : mem[rdPtr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because popData is gated by empty.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues one outstanding req/ack fetch at a time,
// reserving a FIFO slot at issue so returned words always fit. Redirects
// flush the FIFO; a request already in flight is finished and its word
// dropped (DISCARD state).
// Optional build macro FETCH_PERF_EN adds perf_fetch_cnt / perf_flush_cnt.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               stall_d,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [31:0]        pc_plus4_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t          state, stateNext;
    logic [31:0]           reqAddr, reqAddrNext;
    logic [31:0]           fetchPc, fetchPcNext;
    logic                  push, pop, flush;
    logic [CW-1:0]         count;
    logic [CW-1:0]         occNext;
    logic                  fifoEmpty;
    logic                  slotFree;
    logic [2*INSTR_W-1:0]  popData;

    // The in-flight request occupies a slot of its own; the next one may
    // issue only if the FIFO, after this cycle's push/pop, still has room.
    assign push     = (state == WAIT) && imem_ack && !redirect_valid;
    assign pop      = !fifoEmpty && !stall_d && !redirect_valid;
    assign flush    = redirect_valid;
    assign occNext  = count + CW'(push) - CW'(pop);
    assign slotFree = (occNext < DEPTH_C);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * INSTR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushData ({imem_rdata, reqAddr + PC_INC}),
        .pop      (pop),
        .flush    (flush),
        .popData  (popData),
        .count    (count),
        .empty    (fifoEmpty)
    );

    // State, request address and next fetch PC registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            reqAddr <= RESET_PC;
            fetchPc <= RESET_PC;
        end else begin
            state   <= stateNext;
            reqAddr <= reqAddrNext;
            fetchPc <= fetchPcNext;
        end
    end

    // Next-state, issue and redirect handling.
    always_comb begin
        stateNext   = state;
        reqAddrNext = reqAddr;
        fetchPcNext = fetchPc;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    stateNext   = WAIT;
                    reqAddrNext = redirect_pc;
                    fetchPcNext = redirect_pc + PC_INC;
                end else if (slotFree) begin
                    stateNext   = WAIT;
                    reqAddrNext = fetchPc;
                    fetchPcNext = fetchPc + PC_INC;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        reqAddrNext = redirect_pc;
                        fetchPcNext = redirect_pc + PC_INC;
                    end else if (slotFree) begin
                        reqAddrNext = fetchPc;
                        fetchPcNext = fetchPc + PC_INC;
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (redirect_valid) begin
                    stateNext   = DISCARD;
                    fetchPcNext = redirect_pc;
                end
            end
            DISCARD: begin
                if (redirect_valid) fetchPcNext = redirect_pc;
                if (imem_ack)       stateNext   = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign imem_req     = (state == WAIT) || (state == DISCARD);
    assign imem_addr    = reqAddr;
    assign instr_valid  = !fifoEmpty;
    assign instr_out    = popData[2*INSTR_W-1:INSTR_W];
    assign pc_plus4_out = popData[31:0];

`ifdef FETCH_PERF_EN
    // Saturating counts of accepted words and redirect cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (push)           perf_fetch_cnt <= satInc(perf_fetch_cnt);
            if (redirect_valid) perf_flush_cnt <= satInc(perf_flush_cnt);
        end
    end
`endif

endmodule
